// File: rtl/io_bus_if.sv
// MCS IO bus signal bundle: initiator (master) drives strobes/address/data,
// responder (slave) returns read data and a one-cycle ready pulse.
interface io_bus_if;
  logic        IO_AE;
  logic        IO_RE;
  logic        IO_WE;
  logic [31:0] IO_SA;
  logic [3:0]  IO_BYTES;
  logic [31:0] IO_DOUT;
  logic [31:0] IO_DIN;
  logic        IO_READY;

  modport master (output IO_AE, IO_RE, IO_WE, IO_SA, IO_BYTES, IO_DOUT,
                  input  IO_DIN, IO_READY);
  modport slave  (input  IO_AE, IO_RE, IO_WE, IO_SA, IO_BYTES, IO_DOUT,
                  output IO_DIN, IO_READY);
endinterface

// File: rtl/io_bus_responder.sv
// MCS IO bus responder: windowed register bank (ID, scratch, compare timer, LED, keys).
// Define IO_RESP_IRQ_EN to add the irq output and the CTRL.irqen bit.
module io_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FFE0,
  parameter logic [31:0] ID_VALUE    = 32'h1057_0001,
  parameter int          WAIT_STATES = 0,
  parameter int          LED_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  io_bus_if.slave          bus,
  output logic [LED_W-1:0] led,
  input  logic [LED_W-1:0] key
`ifdef IO_RESP_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

`ifdef IO_RESP_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  state_t      state, state_n;
  logic [3:0]  wcnt, wcnt_n;
  logic        latch;
  logic [2:0]  idx_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic        re_q, we_q;

  logic [31:0] scratch, count, compare;
  logic [2:0]  ctrl;
  logic        st_hit;
  logic [LED_W-1:0] key_s1, key_s2;
  logic [31:0] rdata;
  logic        ack, wr, match;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  wire win_hit = (bus.IO_SA & ADDR_MASK) == BASE_ADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    latch   = 1'b0;
    case (state)
      S_IDLE:
        if (bus.IO_AE && win_hit) begin
          latch   = 1'b1;
          wcnt_n  = '0;
          state_n = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      S_WAIT:
        if (wcnt == WS_LAST) state_n = S_ACK;
        else                 wcnt_n  = wcnt + 4'd1;
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      be_q  <= '0;
      wd_q  <= '0;
      re_q  <= 1'b0;
      we_q  <= 1'b0;
    end else if (latch) begin
      idx_q <= bus.IO_SA[4:2];
      be_q  <= bus.IO_BYTES;
      wd_q  <= bus.IO_DOUT;
      re_q  <= bus.IO_RE;
      we_q  <= bus.IO_WE;
    end
  end

  assign ack   = (state == S_ACK);
  assign wr    = ack && we_q;
  assign match = ctrl[0] && (count == compare);

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
      compare <= '0;
      count   <= '0;
      ctrl    <= '0;
      st_hit  <= 1'b0;
      led     <= '0;
      key_s1  <= '0;
      key_s2  <= '0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      if (wr && idx_q == 3'd1) scratch <= merge(scratch, wd_q, be_q);
      if (wr && idx_q == 3'd5) compare <= merge(compare, wd_q, be_q);
      if (wr && idx_q == 3'd2 && be_q[0]) ctrl <= wd_q[2:0] & CTRL_MASK;
      if (wr && idx_q == 3'd6 && be_q[0]) led <= wd_q[LED_W-1:0];
      // Bus write wins over reload/increment in the same cycle
      if (wr && idx_q == 3'd4)  count <= merge(count, wd_q, be_q);
      else if (match && ctrl[1]) count <= '0;
      else if (ctrl[0])          count <= count + 32'd1;
      // A fresh hit survives a concurrent W1C
      st_hit <= match | (st_hit & ~(wr && idx_q == 3'd3 && be_q[0] && wd_q[0]));
    end
  end

`ifdef IO_RESP_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= st_hit & ctrl[2];
  end
`endif

  always_comb begin
    rdata = '0;
    case (idx_q)
      3'd0: rdata = ID_VALUE;
      3'd1: rdata = scratch;
      3'd2: rdata = {29'd0, ctrl};
      3'd3: rdata = {31'd0, st_hit};
      3'd4: rdata = count;
      3'd5: rdata = compare;
      3'd6: rdata = {{(32-LED_W){1'b0}}, led};
      3'd7: rdata = {{(32-LED_W){1'b0}}, key_s2};
      default: rdata = '0;
    endcase
  end

  // Zero outside the ack cycle so several responders can be ORed together
  assign bus.IO_DIN   = (ack && re_q) ? rdata : 32'd0;
  assign bus.IO_READY = ack;

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench: one responder with no wait states, one with three.
module tb_io_bus_responder;
  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam logic [31:0] IDV  = 32'h1057_0001;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst3 = 1'b1;
  logic [3:0] key = 4'h0;
  logic [3:0] led0, led3;
`ifdef IO_RESP_IRQ_EN
  logic irq0, irq3;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  io_bus_if b0();
  io_bus_if b3();

  io_bus_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .bus(b0.slave), .led(led0), .key(key)
`ifdef IO_RESP_IRQ_EN
    , .irq(irq0)
`endif
  );
  io_bus_responder #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(b3.slave), .led(led3), .key(key)
`ifdef IO_RESP_IRQ_EN
    , .irq(irq3)
`endif
  );

  task automatic drive(input int d, input logic ae, input logic re, input logic we,
                       input logic [31:0] sa, input logic [3:0] be, input logic [31:0] wd);
    if (d == 0) begin
      b0.IO_AE = ae; b0.IO_RE = re; b0.IO_WE = we; b0.IO_SA = sa; b0.IO_BYTES = be; b0.IO_DOUT = wd;
    end else begin
      b3.IO_AE = ae; b3.IO_RE = re; b3.IO_WE = we; b3.IO_SA = sa; b3.IO_BYTES = be; b3.IO_DOUT = wd;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? b0.IO_READY : b3.IO_READY;
  endfunction

  function automatic logic [31:0] din(input int d);
    return (d == 0) ? b0.IO_DIN : b3.IO_DIN;
  endfunction

  // One transfer; returns at the negedge of the ack cycle. lat=-1 means no ack.
  task automatic xfer(input int d, input logic re, input logic we, input logic [31:0] sa,
                      input logic [3:0] be, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic leak);
    @(negedge clk); drive(d, 1'b1, re, we, sa, be, wd);
    @(negedge clk); drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    lat = 1; rd = '0; leak = 1'b0;
    while (!rdy(d) && lat < 40) begin
      if (din(d) != 0) leak = 1'b1;
      @(negedge clk); lat++;
    end
    if (rdy(d)) rd = din(d);
    else lat = -1;
  endtask

  task automatic wr(input int d, input logic [4:0] off, input logic [31:0] v, input logic [3:0] be,
                    output int lat);
    logic [31:0] rd; logic leak;
    xfer(d, 1'b0, 1'b1, BASE + 32'(off), be, v, lat, rd, leak);
  endtask

  task automatic rdreg(input int d, input logic [4:0] off, output logic [31:0] v, output int lat);
    logic leak;
    xfer(d, 1'b1, 1'b0, BASE + 32'(off), 4'hF, 32'd0, lat, v, leak);
  endtask

  task automatic test_reset;
    logic [31:0] v; int lat;
    total++; if (b0.IO_READY !== 1'b0 || b0.IO_DIN !== 32'd0) begin bad++;
      $display("FAIL reset_bus0 ready=%b din=%h want 0/0", b0.IO_READY, b0.IO_DIN); end
    total++; if (b3.IO_READY !== 1'b0 || b3.IO_DIN !== 32'd0) begin bad++;
      $display("FAIL reset_bus3 ready=%b din=%h want 0/0", b3.IO_READY, b3.IO_DIN); end
    total++; if (led0 !== 4'h0) begin bad++; $display("FAIL reset_led got=%h want 0", led0); end
    for (int i = 1; i < 7; i++) begin
      rdreg(0, 5'(i*4), v, lat);
      total++; if (v !== 32'd0 || lat != 1) begin bad++;
        $display("FAIL reset_reg%0d got=%h lat=%0d want 0 lat 1", i, v, lat); end
    end
  endtask

  task automatic test_basic;
    logic [31:0] v; int lat;
    wr(0, 5'h04, 32'h1234_5678, 4'hF, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL wr_latency got=%0d want 1", lat); end
    rdreg(0, 5'h04, v, lat);
    total++; if (v !== 32'h1234_5678 || lat != 1) begin bad++;
      $display("FAIL scratch_rd got=%h lat=%0d want 12345678 lat 1", v, lat); end
    wr(0, 5'h00, 32'h0, 4'hF, lat);
    rdreg(0, 5'h00, v, lat);
    total++; if (v !== IDV) begin bad++; $display("FAIL id_ro got=%h want %h", v, IDV); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] v; int lat;
    wr(0, 5'h04, 32'hFFFF_FFFF, 4'hF, lat);
    wr(0, 5'h04, 32'h0000_00AA, 4'b0001, lat);
    rdreg(0, 5'h04, v, lat);
    total++; if (v !== 32'hFFFF_FFAA) begin bad++; $display("FAIL lane0 got=%h want ffffffaa", v); end
    wr(0, 5'h04, 32'h00BB_CC00, 4'b0110, lat);
    rdreg(0, 5'h04, v, lat);
    total++; if (v !== 32'hFFBB_CCAA) begin bad++; $display("FAIL lane12 got=%h want ffbbccaa", v); end
  endtask

  task automatic test_wait_states;
    logic [31:0] v; int lat; logic leak;
    xfer(3, 1'b1, 1'b0, BASE, 4'hF, 32'd0, lat, v, leak);
    total++; if (lat != 4 || v !== IDV) begin bad++;
      $display("FAIL ws3_id lat=%0d data=%h want 4 %h", lat, v, IDV); end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL ws3_din_leak got=%b want 0", leak); end
    @(negedge clk);
    total++; if (b3.IO_READY !== 1'b0 || b3.IO_DIN !== 32'd0) begin bad++;
      $display("FAIL ws3_after ready=%b din=%h want 0/0", b3.IO_READY, b3.IO_DIN); end
  endtask

  task automatic test_out_of_window;
    logic [31:0] v; int lat, seen;
    @(negedge clk); drive(0, 1'b1, 1'b1, 1'b0, BASE + 32'h40, 4'hF, 32'd0);
    @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (b0.IO_READY) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL oow_ready got=%0d want 0", seen); end
    rdreg(0, 5'h04, v, lat);
    total++; if (lat != 1 || v !== 32'hFFBB_CCAA) begin bad++;
      $display("FAIL oow_next lat=%0d data=%h want 1 ffbbccaa", lat, v); end
  endtask

  task automatic test_no_strobe;
    logic [31:0] v; int lat; logic leak;
    xfer(0, 1'b0, 1'b0, BASE + 32'h04, 4'hF, 32'h0, lat, v, leak);
    total++; if (lat != 1 || v !== 32'd0) begin bad++;
      $display("FAIL nostrobe lat=%0d din=%h want 1 0", lat, v); end
    rdreg(0, 5'h04, v, lat);
    total++; if (v !== 32'hFFBB_CCAA) begin bad++; $display("FAIL nostrobe_side got=%h want ffbbccaa", v); end
  endtask

  task automatic test_led_key;
    logic [31:0] v; int lat;
    wr(0, 5'h18, 32'hFFFF_FFF5, 4'hF, lat);
    @(negedge clk);
    total++; if (led0 !== 4'h5) begin bad++; $display("FAIL led got=%h want 5", led0); end
    wr(0, 5'h18, 32'h0000_000A, 4'b1110, lat);
    @(negedge clk);
    total++; if (led0 !== 4'h5) begin bad++; $display("FAIL led_lane got=%h want 5", led0); end
    key = 4'hA;
    repeat (3) @(negedge clk);
    rdreg(0, 5'h1C, v, lat);
    total++; if (v !== 32'h0000_000A) begin bad++; $display("FAIL key got=%h want a", v); end
    wr(0, 5'h1C, 32'h5, 4'hF, lat);
    rdreg(0, 5'h1C, v, lat);
    total++; if (v !== 32'h0000_000A) begin bad++; $display("FAIL key_ro got=%h want a", v); end
  endtask

  task automatic test_timer;
    logic [31:0] v; int lat;
    wr(0, 5'h10, 32'd0, 4'hF, lat);
    wr(0, 5'h14, 32'd5, 4'hF, lat);
    wr(0, 5'h08, 32'h3, 4'hF, lat);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++; if (dut0.count !== 32'(k % 6)) begin bad++;
        $display("FAIL reload_seq k=%0d got=%0d want %0d", k, dut0.count, k % 6); end
    end
    rdreg(0, 5'h0C, v, lat);
    total++; if (v !== 32'd1) begin bad++; $display("FAIL status_hit got=%h want 1", v); end
    wr(0, 5'h08, 32'h0, 4'hF, lat);
    wr(0, 5'h0C, 32'h1, 4'h1, lat);
    rdreg(0, 5'h0C, v, lat);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL status_w1c got=%h want 0", v); end
    // wrap without autoreload
    wr(0, 5'h10, 32'hFFFF_FFFE, 4'hF, lat);
    wr(0, 5'h14, 32'd3, 4'hF, lat);
    wr(0, 5'h08, 32'h1, 4'hF, lat);
    @(negedge clk);
    total++; if (dut0.count !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap0 got=%h want fffffffe", dut0.count); end
    @(negedge clk);
    total++; if (dut0.count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap1 got=%h want ffffffff", dut0.count); end
    @(negedge clk);
    total++; if (dut0.count !== 32'd0) begin bad++; $display("FAIL wrap2 got=%h want 0", dut0.count); end
    // bus write beats increment
    wr(0, 5'h10, 32'd100, 4'hF, lat);
    @(negedge clk);
    total++; if (dut0.count !== 32'd100) begin bad++; $display("FAIL wr_prio got=%0d want 100", dut0.count); end
    @(negedge clk);
    total++; if (dut0.count !== 32'd101) begin bad++; $display("FAIL wr_prio_inc got=%0d want 101", dut0.count); end
    wr(0, 5'h08, 32'h0, 4'hF, lat);
  endtask

  task automatic test_irq;
    logic [31:0] v; int lat;
    wr(0, 5'h0C, 32'h1, 4'h1, lat);
    wr(0, 5'h10, 32'd0, 4'hF, lat);
    wr(0, 5'h08, 32'h5, 4'hF, lat);
    rdreg(0, 5'h08, v, lat);
`ifdef IO_RESP_IRQ_EN
    total++; if (v !== 32'h5) begin bad++; $display("FAIL ctrl_rd got=%h want 5", v); end
    repeat (8) @(negedge clk);
    total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL irq_set got=%b want 1", irq0); end
    wr(0, 5'h08, 32'h4, 4'hF, lat);
    wr(0, 5'h0C, 32'h1, 4'h1, lat);
    @(negedge clk);
    @(negedge clk);
    total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b want 0", irq0); end
`else
    total++; if (v !== 32'h1) begin bad++; $display("FAIL ctrl_rd got=%h want 1", v); end
`endif
    wr(0, 5'h08, 32'h0, 4'hF, lat);
  endtask

  task automatic test_busy_ignore;
    logic [31:0] v; int lat, seen;
    @(negedge clk); drive(3, 1'b1, 1'b1, 1'b0, BASE, 4'hF, 32'd0);
    @(negedge clk); drive(3, 1'b1, 1'b0, 1'b1, BASE + 32'h04, 4'hF, 32'h5555_5555);
    @(negedge clk); drive(3, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (b3.IO_READY) seen++;
      @(negedge clk);
    end
    total++; if (seen != 1) begin bad++; $display("FAIL busy_acks got=%0d want 1", seen); end
    rdreg(3, 5'h04, v, lat);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL busy_side got=%h want 0", v); end
  endtask

  task automatic test_rst_mid;
    logic [31:0] v; int lat, seen;
    @(negedge clk); drive(3, 1'b1, 1'b0, 1'b1, BASE + 32'h04, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk); drive(3, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk); rst3 = 1'b1;
    @(negedge clk); rst3 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (b3.IO_READY) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_ready got=%0d want 0", seen); end
    rdreg(3, 5'h04, v, lat);
    total++; if (v !== 32'd0 || lat != 4) begin bad++;
      $display("FAIL rst_mid_after data=%h lat=%0d want 0 4", v, lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v; int lat;
    for (int i = 0; i < 4; i++) begin
      wr(0, 5'h04, 32'h1111_1111 * 32'(i + 1), 4'hF, lat);
      rdreg(0, 5'h04, v, lat);
      total++; if (v !== 32'h1111_1111 * 32'(i + 1) || lat != 1) begin bad++;
        $display("FAIL b2b%0d got=%h lat=%0d", i, v, lat); end
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_byte_lanes;
    test_wait_states;
    test_out_of_window;
    test_no_strobe;
    test_led_key;
    test_timer;
    test_irq;
    test_busy_ignore;
    test_rst_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
